// File: rtl/mem_stage_pkg.sv
// Shared types and encodings for the RV32I memory stage.
// Holds FSM states, funct3 access sizes and writeback source selects.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

endpackage

// File: rtl/memory_stage_lsu_align.sv
// Byte-lane steering for stores and load extraction/extension.
// Purely combinational; shared by request issue and writeback capture.
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Store lanes, replication and alignment fault detection
  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    misalign  = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        be        = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      F3_W: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      default: misalign = 1'b1;
    endcase
    // unsigned sizes have no store form
    if (store && funct3[2]) misalign = 1'b1;
  end

  // Load lane select and sign/zero extension
  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RV32I memory stage: req/ack data-memory access with pipeline stall,
// load alignment and the MEM/WB pipeline register.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RegWriteM,
  input  logic                     MemWriteM,
  input  logic [1:0]               ResultSrcM,
  input  logic [2:0]               Funct3M,
  input  logic [ADDRESS_WIDTH-1:0] RdM,
  input  logic [DATA_WIDTH-1:0]    ALUResultM,
  input  logic [DATA_WIDTH-1:0]    WriteDataM,
  input  logic [DATA_WIDTH-1:0]    PCPlus4M,
  output logic                     StallM,
  output logic                     MemReq,
  output logic                     MemWE,
  output logic [31:0]              MemAddr,
  output logic [31:0]              MemWData,
  output logic [3:0]               MemBE,
  input  logic                     MemAck,
  input  logic [31:0]              MemRData,
  output logic                     RegWriteW,
  output logic [1:0]               ResultSrcW,
  output logic [ADDRESS_WIDTH-1:0] RdW,
  output logic [DATA_WIDTH-1:0]    ALUResultW,
  output logic [DATA_WIDTH-1:0]    ReadDataW,
  output logic [DATA_WIDTH-1:0]    PCPlus4W,
  output logic                     MisalignW
);

  state_t      state, state_nx;
  logic        access;
  logic        mis;
  logic        start;
  logic        fault;
  logic        ack_ok;
  logic [3:0]  be_c;
  logic [31:0] wrep_c;
  logic [31:0] ld_c;
  logic [31:0] rlatch;

  assign access = MemWriteM | (ResultSrcM == RS_MEM);
  assign start  = (state == IDLE) & access & ~mis;
  assign fault  = (state == IDLE) & access & mis;
  assign ack_ok = (state == BUSY) & MemAck;

  lsu_align u_align (
    .store     (MemWriteM),
    .funct3    (Funct3M),
    .addr_lo   (ALUResultM[1:0]),
    .wdata     (WriteDataM),
    .rdata     (rlatch),
    .be        (be_c),
    .wdata_rep (wrep_c),
    .misalign  (mis),
    .load_data (ld_c)
  );

  // Access sequencing state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and stall; the stall rises in the same cycle the access arrives
  always_comb begin
    state_nx = state;
    StallM   = 1'b0;
    unique case (state)
      IDLE: begin
        if (access && !mis) begin
          state_nx = BUSY;
          StallM   = 1'b1;
        end
      end
      BUSY: begin
        StallM = 1'b1;
        if (MemAck) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request registers, loaded on issue and held until the ack
  always_ff @(posedge CLK) begin
    if (RST) begin
      MemReq   <= 1'b0;
      MemWE    <= 1'b0;
      MemBE    <= 4'b0000;
      MemAddr  <= 32'h0;
      MemWData <= 32'h0;
    end else if (start) begin
      MemReq   <= 1'b1;
      MemWE    <= MemWriteM;
      MemBE    <= be_c;
      MemAddr  <= {ALUResultM[31:2], 2'b00};
      MemWData <= wrep_c;
    end else if (ack_ok) begin
      MemReq <= 1'b0;
      MemWE  <= 1'b0;
      MemBE  <= 4'b0000;
    end
  end

  // Read-data latch, only written by an ack that arrives while busy
  always_ff @(posedge CLK) begin
    if (RST)         rlatch <= 32'h0;
    else if (ack_ok) rlatch <= MemRData;
  end

  // MEM/WB register: capture when not stalled, otherwise insert a bubble
  always_ff @(posedge CLK) begin
    if (RST) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= RS_ALU;
      RdW        <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      MisalignW  <= 1'b0;
    end else begin
      MisalignW <= fault;
      if (StallM) begin
        RegWriteW  <= 1'b0;
        ResultSrcW <= RS_ALU;
      end else begin
        RegWriteW  <= RegWriteM & ~fault;
        ResultSrcW <= ResultSrcM;
        RdW        <= RdM;
        ALUResultW <= ALUResultM;
        ReadDataW  <= ld_c;
        PCPlus4W   <= PCPlus4M;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
// Vector table plus hand sequences for reset and back-to-back cases.
module tb_memory_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic        StallM, MemReq, MemWE;
  logic [31:0] MemAddr, MemWData;
  logic [3:0]  MemBE;
  logic        MemAck;
  logic [31:0] MemRData;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic        MisalignW;

  int checks = 0;
  int errors = 0;

  memory_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RdM(RdM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .StallM(StallM), .MemReq(MemReq), .MemWE(MemWE),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemBE(MemBE),
    .MemAck(MemAck), .MemRData(MemRData),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .MisalignW(MisalignW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ack_n;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic        e_rw;
    logic        e_mis;
    int          e_stall;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic rw, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc4);
    MemWriteM  = we;
    ResultSrcM = rs;
    Funct3M    = f3;
    RdM        = rd;
    RegWriteM  = rw;
    ALUResultM = alu;
    WriteDataM = wd;
    PCPlus4M   = pc4;
  endtask

  // Called just after a posedge; returns just after the edge that retires it.
  task automatic run(input int i, input vec_t v);
    int stalls = 0;
    int reqs = 0;
    int e_req;
    bit fin = 0;
    logic [31:0] pc4;
    pc4 = 32'h1000 + 32'(i * 4);
    e_req = (v.e_stall == 0) ? 0 : v.ack_n;
    drive(v.we, v.rs, v.f3, v.rd, v.rw, v.alu, v.wd, pc4);
    MemRData = v.rdata;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge CLK);
      if (StallM) stalls++;
      else fin = 1;
      if (MemReq) begin
        reqs++;
        chk($sformatf("v%0d addr", i), MemAddr, v.alu & 32'hFFFF_FFFC);
        chk($sformatf("v%0d we", i), 32'(MemWE), 32'(v.we));
        if (v.we) begin
          chk($sformatf("v%0d be", i), 32'(MemBE), 32'(v.e_be));
          chk($sformatf("v%0d wdata", i), MemWData, v.e_wd);
        end
        if (reqs == v.ack_n) MemAck = 1'b1;
      end
      @(posedge CLK);
      #1;
      MemAck = 1'b0;
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL v%0d timeout: stall still %b after 40 cycles", i, StallM);
    end
    chk($sformatf("v%0d stall_cycles", i), 32'(stalls), 32'(v.e_stall));
    chk($sformatf("v%0d req_cycles", i), 32'(reqs), 32'(e_req));
    chk($sformatf("v%0d RegWriteW", i), 32'(RegWriteW), 32'(v.e_rw));
    chk($sformatf("v%0d MisalignW", i), 32'(MisalignW), 32'(v.e_mis));
    chk($sformatf("v%0d RdW", i), 32'(RdW), 32'(v.rd));
    chk($sformatf("v%0d ResultSrcW", i), 32'(ResultSrcW), 32'(v.rs));
    chk($sformatf("v%0d ALUResultW", i), ALUResultW, v.alu);
    chk($sformatf("v%0d PCPlus4W", i), PCPlus4W, pc4);
    if (v.rs == 2'b01 && !v.e_mis)
      chk($sformatf("v%0d ReadDataW", i), ReadDataW, v.e_rd);
  endtask

  function automatic vec_t mk(
    logic we, logic [1:0] rs, logic [2:0] f3, logic [4:0] rd, logic rw,
    logic [31:0] alu, logic [31:0] wd, logic [31:0] rdata, int ack_n,
    logic [3:0] e_be, logic [31:0] e_wd, logic [31:0] e_rd,
    logic e_rw, logic e_mis, int e_stall);
    vec_t v;
    v.we = we; v.rs = rs; v.f3 = f3; v.rd = rd; v.rw = rw;
    v.alu = alu; v.wd = wd; v.rdata = rdata; v.ack_n = ack_n;
    v.e_be = e_be; v.e_wd = e_wd; v.e_rd = e_rd;
    v.e_rw = e_rw; v.e_mis = e_mis; v.e_stall = e_stall;
    return v;
  endfunction

  initial begin
    int n;
    // we rs f3 rd rw alu wd rdata ack | be wd rd rw mis stall
    vt[0]  = mk(1, 2'b00, 3'b010, 5'd0, 0, 32'h100, 32'hDEADBEEF, 32'h0, 1,
                4'b1111, 32'hDEADBEEF, 32'h0, 0, 0, 2);
    vt[1]  = mk(1, 2'b00, 3'b000, 5'd0, 0, 32'h103, 32'h000000A5, 32'h0, 1,
                4'b1000, 32'hA5A5A5A5, 32'h0, 0, 0, 2);
    vt[2]  = mk(0, 2'b01, 3'b000, 5'd5, 1, 32'h103, 32'h0, 32'hA5000000, 2,
                4'b0, 32'h0, 32'hFFFFFFA5, 1, 0, 3);
    vt[3]  = mk(0, 2'b01, 3'b100, 5'd6, 1, 32'h103, 32'h0, 32'hA5000000, 1,
                4'b0, 32'h0, 32'h000000A5, 1, 0, 2);
    vt[4]  = mk(0, 2'b01, 3'b001, 5'd7, 1, 32'h102, 32'h0, 32'h80010000, 4,
                4'b0, 32'h0, 32'hFFFF8001, 1, 0, 5);
    vt[5]  = mk(0, 2'b01, 3'b101, 5'd8, 1, 32'h102, 32'h0, 32'h80010000, 1,
                4'b0, 32'h0, 32'h00008001, 1, 0, 2);
    vt[6]  = mk(0, 2'b01, 3'b010, 5'd9, 1, 32'h101, 32'h0, 32'h11111111, 1,
                4'b0, 32'h0, 32'h0, 0, 1, 0);
    vt[7]  = mk(0, 2'b00, 3'b000, 5'd10, 1, 32'h55, 32'h0, 32'h0, 1,
                4'b0, 32'h0, 32'h0, 1, 0, 0);
    vt[8]  = mk(1, 2'b00, 3'b001, 5'd0, 0, 32'h102, 32'h0000BEEF, 32'h0, 1,
                4'b1100, 32'hBEEFBEEF, 32'h0, 0, 0, 2);
    vt[9]  = mk(0, 2'b01, 3'b000, 5'd11, 1, 32'h100, 32'h0, 32'h0000007F, 1,
                4'b0, 32'h0, 32'h0000007F, 1, 0, 2);
    vt[10] = mk(0, 2'b01, 3'b010, 5'd12, 1, 32'h104, 32'h0, 32'hCAFEF00D, 3,
                4'b0, 32'h0, 32'hCAFEF00D, 1, 0, 4);
    vt[11] = mk(0, 2'b00, 3'b000, 5'd13, 1, 32'h99, 32'h0, 32'h0, 1,
                4'b0, 32'h0, 32'h0, 1, 0, 0);
    vt[12] = mk(1, 2'b00, 3'b001, 5'd0, 0, 32'h101, 32'h1234, 32'h0, 1,
                4'b0, 32'h0, 32'h0, 0, 1, 0);
    vt[13] = mk(0, 2'b01, 3'b011, 5'd14, 1, 32'h100, 32'h0, 32'h0, 1,
                4'b0, 32'h0, 32'h0, 0, 1, 0);
    vt[14] = mk(0, 2'b10, 3'b000, 5'd1, 1, 32'h2000, 32'h0, 32'h0, 1,
                4'b0, 32'h0, 32'h0, 1, 0, 0);
    vt[15] = mk(0, 2'b01, 3'b001, 5'd15, 1, 32'h103, 32'h0, 32'h0, 1,
                4'b0, 32'h0, 32'h0, 0, 1, 0);

    RST = 1'b1;
    MemAck = 1'b0;
    MemRData = 32'h0;
    drive(0, 2'b00, 3'b000, 5'd0, 0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst MemReq", 32'(MemReq), 32'h0);
    chk("rst MemWE", 32'(MemWE), 32'h0);
    chk("rst MemBE", 32'(MemBE), 32'h0);
    chk("rst MemAddr", MemAddr, 32'h0);
    chk("rst MemWData", MemWData, 32'h0);
    chk("rst StallM", 32'(StallM), 32'h0);
    chk("rst RegWriteW", 32'(RegWriteW), 32'h0);
    chk("rst MisalignW", 32'(MisalignW), 32'h0);
    chk("rst RdW", 32'(RdW), 32'h0);
    chk("rst ReadDataW", ReadDataW, 32'h0);
    @(posedge CLK);
    #1;

    foreach (vt[i]) run(i, vt[i]);

    // misalign pulse must drop after one cycle
    drive(0, 2'b00, 3'b000, 5'd3, 1, 32'h7, 32'h0, 32'h0);
    @(negedge CLK);
    chk("nop StallM", 32'(StallM), 32'h0);
    @(posedge CLK);
    #1;
    chk("pulse MisalignW", 32'(MisalignW), 32'h0);
    chk("nop RdW", 32'(RdW), 32'h3);

    // reset while busy, then a late ack
    drive(0, 2'b01, 3'b010, 5'd20, 1, 32'h200, 32'h0, 32'h0);
    n = 0;
    while (!MemReq && n < 10) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("rstbusy reached", 32'(MemReq), 32'h1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drive(0, 2'b00, 3'b000, 5'd0, 0, 32'h0, 32'h0, 32'h0);
    MemRData = 32'h12345678;
    MemAck = 1'b1;
    @(negedge CLK);
    chk("rstbusy MemReq", 32'(MemReq), 32'h0);
    chk("rstbusy StallM", 32'(StallM), 32'h0);
    chk("rstbusy RegWriteW", 32'(RegWriteW), 32'h0);
    @(posedge CLK);
    #1;
    MemAck = 1'b0;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("lateack MemReq", 32'(MemReq), 32'h0);
    chk("lateack StallM", 32'(StallM), 32'h0);
    chk("lateack RegWriteW", 32'(RegWriteW), 32'h0);
    chk("lateack RdW", 32'(RdW), 32'h0);
    chk("lateack ALUResultW", ALUResultW, 32'h0);
    chk("lateack ReadDataW", ReadDataW, 32'h0);
    chk("lateack MisalignW", 32'(MisalignW), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory-access stage of the pipelined RV32I core, sitting directly downstream of the Execute→Memory pipeline register and feeding the Writeback stage. It issues loads and stores to a variable-latency data-memory port through a req/ack handshake, and stalls the pipeline while an access is outstanding. It aligns and sign/zero-extends load data, and registers the Memory→Writeback state (it is the MEM/WB pipeline register).

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width (only 32 supported)
- ADDRESS_WIDTH, 5, register-file address width

Ports:
- CLK  in  1  clock, all state on posedge
- RST  in  1  synchronous, active-high reset
- RegWriteM, MemWriteM  in  1 each  control from EX/MEM register
- ResultSrcM  in  2  00 ALU, 01 memory (load), 10 PC+4
- Funct3M  in  3  access size/sign
- RdM  in  ADDRESS_WIDTH  destination register
- ALUResultM, WriteDataM, PCPlus4M  in  DATA_WIDTH  address / store data / link value
- StallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM registers
- MemReq, MemWE  out  1 each  request strobe, write enable
- MemAddr  out  32  word-aligned address ({ALUResultM[31:2],2'b00})
- MemWData  out  32  lane-replicated store data
- MemBE  out  4  byte enables
- MemAck  in  1  access complete; rdata valid on this cycle for reads
- MemRData  in  32  raw read word
- RegWriteW  out  1, ResultSrcW  out  2, RdW  out  ADDRESS_WIDTH
- ALUResultW, ReadDataW, PCPlus4W  out  DATA_WIDTH
- MisalignW  out  1  one-cycle fault pulse for a dropped access

## Operation
- Access = MemWriteM | (ResultSrcM==01). Valid sizes: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only).
- Misaligned: H with addr[0]=1; W with addr[1:0]≠0. An invalid funct3 is treated as misaligned. A misaligned access issues no request and no stall; at the next edge RegWriteW=0 and MisalignW=1.
- FSM states:
  - IDLE: on an aligned access, go to BUSY; StallM=1 combinationally.
  - BUSY: MemReq=1, StallM=1. On MemAck, capture MemRData into an internal latch and go to DONE.
  - DONE: StallM=0; the W register captures the stage outputs; return to IDLE.
- MemReq, MemWE, MemAddr, MemWData and MemBE are registered on IDLE→BUSY and held stable until the ack.
- MemAck is ignored outside BUSY.
- Store lanes:
  - SB: MemBE=0001<<addr[1:0], byte replicated ×4.
  - SH: MemBE=0011<<addr[1:0], half replicated ×2.
  - SW: MemBE=1111.
- Load: select byte/half via addr[1:0], then sign- (B/H) or zero-extend (BU/HU). LW passes the word through.
- W register, when StallM=0: capture RegWriteM, ResultSrcM, RdM, ALUResultM, PCPlus4M, and aligned load data into ReadDataW.
- W register, when StallM=1: load a bubble (RegWriteW=0, ResultSrcW=00, other fields hold).
- Non-access instructions pass through in one cycle with no stall.

## Timing
- Reset values: state IDLE; MemReq, MemWE, MemBE, StallM-contributing state, RegWriteW, MisalignW, ResultSrcW = 0; RdW, all W data outputs and MemAddr/MemWData = 0.
- Access latency: the instruction occupies MEM for 2+N cycles, where N = cycles from MemReq rising to MemAck (N≥1; ack is sampled at the first BUSY edge at the earliest).
- With an ack one cycle after the request, StallM is high for exactly 2 cycles.
- Back-to-back accesses: DONE→IDLE, and the next access raises StallM in that same IDLE cycle. There is no overlap of requests.
- Reset mid-access: state→IDLE and MemReq=0 at the next edge. A late ack is ignored, and the W register holds its reset bubble.
- RST has priority over all other events.

## Structure
- Package mem_stage_pkg:
  - state_t enum {IDLE, BUSY, DONE}
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - ResultSrc encodings (RS_ALU, RS_MEM, RS_PC4)
- Sub-module lsu_align: purely combinational.
  - Store path: (funct3, addr[1:0], wdata) → (be, wdata_rep, misalign).
  - Load path: (funct3, addr[1:0], rdata) → extended data.
- The top level holds the FSM, request registers and the W register.

## Test plan
- Store word, addr 0x100, data 0xDEADBEEF, ack 1 cycle after req → MemBE=1111, MemWData=0xDEADBEEF, StallM high 2 cycles, RegWriteW=0.
- SB addr 0x103, data 0x000000A5 → MemBE=1000, MemWData=0xA5A5A5A5. Then LB at addr 0x103 with rdata 0xA5000000 → ReadDataW=0xFFFFFFA5; LBU gives 0x000000A5.
- LH at addr 0x102, rdata 0x80010000, ack after 4 cycles → StallM high 5 cycles, MemReq stable 4 cycles, ReadDataW=0xFFFF8001, RegWriteW=1 with RdM.
- LW at addr 0x101 → no MemReq, StallM=0, next cycle MisalignW=1 and RegWriteW=0.
- RST asserted while in BUSY, followed by a MemAck → MemReq=0 next cycle, state IDLE, ack ignored, all W outputs 0.
- ALU op (ResultSrc 00, RegWrite 1) directly after a load → the ALU op sees StallM=0 in the DONE/IDLE cycles, with W updated one cycle later and no duplicated RegWriteW.
